// File: rtl/accu_pkg.sv
// Constants shared by the 4-sample accumulator and its downstream sum buffer.
package accu_pkg;
    localparam int ACC_IN_W  = 8;
    localparam int ACC_SUM_W = 10;
    localparam int ACC_GROUP = 4;
    localparam int AVG_SHIFT = 2;   // log2(ACC_GROUP)
endpackage

// File: rtl/accu_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module accu_fifo_mem #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/accu_sum_buffer.sv
// FWFT buffer for accumulator group sums with valid/ready output, average tap
// and sticky overflow / saturating drop counter.
module accu_sum_buffer
    import accu_pkg::*;
#(
    parameter int DW    = ACC_SUM_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            sum_in,
    input  logic                     sum_valid,
    output logic [DW-1:0]            out_data,
    output logic [DW-AVG_SHIFT-1:0]  out_avg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic [AW:0]      level_next;
    logic             nonempty;
    logic [DW-1:0]    rdata;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign full = (level_q == FULL_LVL);
    assign pop  = nonempty & out_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign push = sum_valid & (~full | pop);
    assign drop = sum_valid & full & ~pop;

    always_comb begin
        level_next = level_q;
        unique case ({push, pop})
            2'b10:   level_next = level_q + (AW+1)'(1);
            2'b01:   level_next = level_q - (AW+1)'(1);
            default: level_next = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            nonempty <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q  <= level_next;
            nonempty <= (level_next != '0);
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (clr_ovf) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end
    end

    accu_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (sum_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign out_valid = nonempty;
    assign out_data  = nonempty ? rdata : '0;
    assign out_avg   = out_data[DW-1:AVG_SHIFT];
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = cnt_q;
endmodule

// File: tb/tb_accu_sum_buffer.sv
// Scoreboard bench for accu_sum_buffer: directed scenarios plus a random phase.
module tb_accu_sum_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sum_in = '0;
    logic       sum_valid = 1'b0;
    logic [9:0] out_data;
    logic [7:0] out_avg;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf = 1'b0;

    int checks = 0;
    int failures = 0;

    int exp_q[$];
    int m_ovf = 0;
    int m_cnt = 0;

    accu_sum_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .out_data  (out_data),
        .out_avg   (out_avg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the FIFO is a plain queue of expected sums, advanced each
    // cycle from the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        int  sz;
        bit  pop;
        bit  drop;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0;
            m_cnt = 0;
            check("rst_valid", int'(out_valid), 0);
            check("rst_level", int'(level), 0);
            check("rst_data", int'(out_data), 0);
            check("rst_ovf", int'(overflow), 0);
            check("rst_cnt", int'(drop_cnt), 0);
        end else begin
            sz = exp_q.size();
            check("level", int'(level), sz);
            check("out_valid", int'(out_valid), (sz != 0) ? 1 : 0);
            check("overflow", int'(overflow), m_ovf);
            check("drop_cnt", int'(drop_cnt), m_cnt);
            if (sz != 0) begin
                check("out_data", int'(out_data), exp_q[0]);
                check("out_avg", int'(out_avg), exp_q[0] / 4);
            end else begin
                check("idle_data", int'(out_data), 0);
                check("idle_avg", int'(out_avg), 0);
            end
            pop  = (sz != 0) && out_ready;
            drop = sum_valid && (sz == 4) && !pop;
            if (pop) void'(exp_q.pop_front());
            if (sum_valid && !drop) exp_q.push_back(int'(sum_in));
            if (drop) begin
                m_ovf = 1;
                m_cnt = clr_ovf ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (clr_ovf) begin
                m_ovf = 0;
                m_cnt = 0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_one(input int v);
        sum_in    = 10'(v);
        sum_valid = 1'b1;
        step();
        sum_valid = 1'b0;
    endtask

    initial begin
        int t1_vals[3] = '{20, 114, 68};
        int t2_vals[5] = '{20, 114, 68, 4, 1000};

        step(3);
        rst = 1'b0;
        step();

        // 1: streaming with the consumer always ready
        out_ready = 1'b1;
        foreach (t1_vals[i]) begin
            push_one(t1_vals[i]);
            check("t1_level", int'(level), 1);
            check("t1_avg", int'(out_avg), t1_vals[i] / 4);
            step(3);
        end

        // 2: fill and overflow
        out_ready = 1'b0;
        sum_valid = 1'b1;
        foreach (t2_vals[i]) begin
            sum_in = 10'(t2_vals[i]);
            step();
        end
        sum_valid = 1'b0;
        check("t2_level", int'(level), 4);
        check("t2_cnt", int'(drop_cnt), 1);
        check("t2_ovf", int'(overflow), 1);
        out_ready = 1'b1;
        step(6);
        check("t2_drained", int'(level), 0);

        // 3: full with simultaneous push and pop
        out_ready = 1'b0;
        sum_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sum_in = 10'(100 + i);
            step();
        end
        sum_in = 10'd77;
        out_ready = 1'b1;
        step();
        sum_valid = 1'b0;
        out_ready = 1'b0;
        check("t3_level", int'(level), 4);
        check("t3_cnt", int'(drop_cnt), 1);
        out_ready = 1'b1;
        step(6);

        // 4: counter saturation and clear priority
        out_ready = 1'b0;
        sum_valid = 1'b1;
        for (int i = 0; i < 304; i++) begin
            sum_in = 10'($urandom_range(0, 1020));
            step();
        end
        sum_valid = 1'b0;
        check("t4_sat", int'(drop_cnt), 255);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4_clr_ovf", int'(overflow), 0);
        check("t4_clr_cnt", int'(drop_cnt), 0);
        clr_ovf   = 1'b1;
        sum_valid = 1'b1;
        sum_in    = 10'd9;
        step();
        clr_ovf   = 1'b0;
        sum_valid = 1'b0;
        check("t4_both_ovf", int'(overflow), 1);
        check("t4_both_cnt", int'(drop_cnt), 1);
        out_ready = 1'b1;
        step(6);

        // 5: asynchronous reset with three entries held
        out_ready = 1'b0;
        sum_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sum_in = 10'(500 + i);
            step();
        end
        sum_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("t5_async_valid", int'(out_valid), 0);
        check("t5_async_level", int'(level), 0);
        check("t5_async_data", int'(out_data), 0);
        check("t5_async_ovf", int'(overflow), 0);
        check("t5_async_cnt", int'(drop_cnt), 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        push_one(20);
        check("t5_after", int'(out_data), 20);
        step(3);

        // 6: backpressure toggling, values spaced two cycles apart
        for (int i = 1; i <= 6; i++) begin
            sum_in    = 10'(i);
            sum_valid = 1'b1;
            out_ready = ~out_ready;
            step();
            sum_valid = 1'b0;
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b1;
        step(6);
        check("t6_nodrop", int'(drop_cnt), 0);
        check("t6_empty", int'(level), 0);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            sum_valid = ($urandom_range(0, 2) != 0);
            sum_in    = 10'($urandom_range(0, 1020));
            out_ready = ((i / 40) % 3 == 1) ? ($urandom_range(0, 7) == 0)
                                            : ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 63) == 0);
            step();
        end
        sum_valid = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        step(8);
        check("final_level", int'(level), 0);
        check("final_model_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
